stage1_if_prefetch: RTL and testbench

//  Parametrised instruction-fetch front end. It issues pipelined fetch requests over the SRAM-like
//  req/addr_ok/data_ok bus, with up to MAX_OUTSTANDING requests in flight. Returned instructions
//  are queued in an in-order instruction buffer (IBUF) in front of ID. A redirect (branch,

---
 rtl/stage1_if_prefetch.sv | 164 ++++++++++++++++
 tb/tb_stage1_if_prefetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/stage1_if_prefetch.sv
// Instruction-fetch front end. Issues pipelined fetch requests on the
// req/addr_ok/data_ok bus, keeps issued PCs in order, and queues returned
// instructions in an in-order IBUF for ID. Redirects flush everything and
// drop stale in-flight responses by count.
module stage1_if_prefetch #(
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          IBUF_DEPTH      = 4,
    parameter logic [31:0] RESET_PC        = 32'h1C000000
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,

    input  logic        ds_allow_in,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_to_ds_pc,
    output logic [31:0] fs_to_ds_inst,
    output logic        fs_to_ds_adef,

    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    // counter widths hold 0..depth inclusive; CW is wide enough to add two counters
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW  = $clog2(IBUF_DEPTH + 1);
    localparam int CW  = ((OW > BW) ? OW : BW) + 1;
    localparam int PPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int BPW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } ibuf_ent_t;

    // fetch state
    logic [31:0]   pc;
    logic          adef_stall;
    logic [OW-1:0] live;
    logic [OW-1:0] discard_cnt;

    // pending-PC FIFO: PCs of accepted requests whose data will be kept
    logic [31:0]    pend_pc [MAX_OUTSTANDING];
    logic [PPW-1:0] pend_rp;
    logic [PPW-1:0] pend_wp;

    // instruction buffer
    ibuf_ent_t      ibuf [IBUF_DEPTH];
    logic [BPW-1:0] ib_rp;
    logic [BPW-1:0] ib_wp;
    logic [BW-1:0]  ib_count;

    logic [CW-1:0] total_w;
    logic [CW-1:0] credit_w;
    logic          pc_aligned;
    logic          hs;
    logic          ret_keep;
    logic          ret_drop;
    logic          adef_push;
    logic          ib_push;
    logic          ib_pop;
    ibuf_ent_t     ib_din;
    ibuf_ent_t     ib_head;

    function automatic logic [PPW-1:0] pend_inc(input logic [PPW-1:0] p);
        return (p == PPW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [BPW-1:0] ib_inc(input logic [BPW-1:0] p);
        return (p == BPW'(IBUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign total_w    = CW'(live) + CW'(discard_cnt);
    assign credit_w   = CW'(live) + CW'(ib_count);
    assign pc_aligned = (pc[1:0] == 2'b00);

    // a request is only made when a kept response is guaranteed an IBUF slot
    assign inst_sram_req = !reset && !redirect_valid && !adef_stall && pc_aligned
                         && (total_w < CW'(MAX_OUTSTANDING))
                         && (credit_w < CW'(IBUF_DEPTH));
    assign inst_sram_addr  = pc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_wdata = 32'h0;

    assign hs       = inst_sram_req && inst_sram_addr_ok;
    // redirect-cycle responses are consumed by the discard_cnt load instead
    assign ret_keep = inst_sram_data_ok && !reset && !redirect_valid && (discard_cnt == '0);
    assign ret_drop = inst_sram_data_ok && !reset && !redirect_valid && (discard_cnt != '0);
    // a misaligned PC turns into a single ADEF entry once older kept fetches have landed
    assign adef_push = !reset && !redirect_valid && !adef_stall && !pc_aligned
                     && (live == '0) && (ib_count < BW'(IBUF_DEPTH));

    // kept returns and ADEF pushes are exclusive: an ADEF push needs live==0
    always_comb begin
        ib_din = '{pc: pc, inst: 32'h0, adef: 1'b1};
        if (ret_keep) ib_din = '{pc: pend_pc[pend_rp], inst: inst_sram_rdata, adef: 1'b0};
    end

    assign ib_push = ret_keep || adef_push;
    assign ib_head = ibuf[ib_rp];

    assign fs_to_ds_valid = !reset && (ib_count != '0);
    assign fs_to_ds_pc    = ib_head.pc;
    assign fs_to_ds_inst  = ib_head.inst;
    assign fs_to_ds_adef  = ib_head.adef;
    assign ib_pop         = fs_to_ds_valid && ds_allow_in && !redirect_valid;

    // control state: reset, then redirect flush, then normal issue/return/drain
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            adef_stall  <= 1'b0;
            live        <= '0;
            discard_cnt <= '0;
            pend_rp     <= '0;
            pend_wp     <= '0;
            ib_rp       <= '0;
            ib_wp       <= '0;
            ib_count    <= '0;
        end else if (redirect_valid) begin
            pc          <= redirect_pc;
            adef_stall  <= 1'b0;
            live        <= '0;
            // every request still on the bus is stale; one returning now is dropped here
            discard_cnt <= OW'(total_w - CW'(inst_sram_data_ok));
            pend_rp     <= '0;
            pend_wp     <= '0;
            ib_rp       <= '0;
            ib_wp       <= '0;
            ib_count    <= '0;
        end else begin
            if (hs) begin
                pc      <= pc + 32'd4;
                pend_wp <= pend_inc(pend_wp);
            end
            if (ret_keep) pend_rp <= pend_inc(pend_rp);
            live <= live + OW'(hs) - OW'(ret_keep);
            if (ret_drop) discard_cnt <= discard_cnt - 1'b1;
            if (adef_push) adef_stall <= 1'b1;
            if (ib_push) ib_wp <= ib_inc(ib_wp);
            if (ib_pop) ib_rp <= ib_inc(ib_rp);
            ib_count <= ib_count + BW'(ib_push) - BW'(ib_pop);
        end
    end

    // FIFO storage; contents are qualified by the pointers/counters above
    always_ff @(posedge clk) begin
        if (hs) pend_pc[pend_wp] <= pc;
        if (ib_push) ibuf[ib_wp] <= ib_din;
    end

endmodule

// File: tb/tb_stage1_if_prefetch.sv
// Directed bench for stage1_if_prefetch: streaming, ID back-pressure,
// redirects with stale responses, ADEF and mid-run reset.
module tb_stage1_if_prefetch;

    localparam logic [31:0] RST_PC = 32'h1C000000;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ds_allow_in;
    logic        fs_to_ds_valid;
    logic [31:0] fs_to_ds_pc;
    logic [31:0] fs_to_ds_inst;
    logic        fs_to_ds_adef;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } id_t;

    logic [31:0] bq[$];   // addresses accepted by the bus, oldest first
    id_t         got[$];  // instructions taken by ID
    logic        ao_en, do_en, saw_req;
    int          n_chk, n_pass;

    stage1_if_prefetch #(.MAX_OUTSTANDING(2), .IBUF_DEPTH(4), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ds_allow_in(ds_allow_in),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_pc(fs_to_ds_pc),
        .fs_to_ds_inst(fs_to_ds_inst), .fs_to_ds_adef(fs_to_ds_adef),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // one clock: drive the bus from the model, record handshakes, advance to next negedge
    task automatic cyc();
        inst_sram_data_ok = do_en && (bq.size() > 0);
        inst_sram_rdata   = (bq.size() > 0) ? mem(bq[0]) : 32'h0;
        inst_sram_addr_ok = ao_en;
        #1;
        if (inst_sram_req) saw_req = 1'b1;
        if (inst_sram_req && inst_sram_addr_ok) bq.push_back(inst_sram_addr);
        if (inst_sram_data_ok) void'(bq.pop_front());
        if (fs_to_ds_valid && ds_allow_in && !redirect_valid)
            got.push_back('{pc: fs_to_ds_pc, inst: fs_to_ds_inst, adef: fs_to_ds_adef});
        @(posedge clk);
        @(negedge clk);
    endtask

    // expect n consecutive aligned instructions starting at base
    task automatic chk_seq(input string tag, input logic [31:0] base, input int n);
        chk({tag, "_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) begin
            chk({tag, "_pc"}, got[i].pc, base + 32'(4 * i));
            chk({tag, "_inst"}, got[i].inst, mem(base + 32'(4 * i)));
            chk({tag, "_adef"}, 32'(got[i].adef), 32'd0);
        end
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        ds_allow_in = 1'b1; ao_en = 1'b1; do_en = 1'b1; saw_req = 1'b0;
        inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
        @(negedge clk);
        cyc();

        // reset state and bus constants
        #1;
        chk("rst_valid", 32'(fs_to_ds_valid), 32'd0);
        chk("rst_req", 32'(inst_sram_req), 32'd0);
        chk("rst_addr", inst_sram_addr, RST_PC);
        chk("const_wr", 32'(inst_sram_wr), 32'd0);
        chk("const_size", 32'(inst_sram_size), 32'd2);
        chk("const_wstrb", 32'(inst_sram_wstrb), 32'd0);
        chk("const_wdata", inst_sram_wdata, 32'd0);
        cyc();
        reset = 1'b0;
        #1;
        chk("first_req", 32'(inst_sram_req), 32'd1);
        chk("first_addr", inst_sram_addr, RST_PC);

        // streaming: one instruction per cycle after a 2-cycle fill
        got.delete();
        repeat (10) cyc();
        chk_seq("stream", RST_PC, 8);

        // ID stalled: fetch stops with the IBUF full, nothing lost
        got.delete();
        ds_allow_in = 1'b0;
        repeat (10) cyc();
        #1;
        chk("stall_req", 32'(inst_sram_req), 32'd0);
        chk("stall_valid", 32'(fs_to_ds_valid), 32'd1);
        chk("stall_head", fs_to_ds_pc, 32'h1C000020);
        chk("stall_inflight", bq.size(), 32'd0);
        chk("stall_taken", got.size(), 32'd0);
        ds_allow_in = 1'b1;
        repeat (8) cyc();
        chk_seq("release", 32'h1C000020, 8);

        // two in flight, redirect, both stale responses dropped
        do_en = 1'b0;
        repeat (4) cyc();
        #1;
        chk("pre_redir_valid", 32'(fs_to_ds_valid), 32'd0);
        chk("pre_redir_req", 32'(inst_sram_req), 32'd0);
        chk("pre_redir_inflight", bq.size(), 32'd2);
        got.delete();
        redirect_valid = 1'b1; redirect_pc = 32'h1C000100;
        cyc();
        redirect_valid = 1'b0; do_en = 1'b1;
        repeat (8) cyc();
        chk_seq("redir", 32'h1C000100, 5);

        // redirect coinciding with data_ok while two are in flight
        do_en = 1'b0;
        cyc();
        do_en = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h1C000200;
        cyc();
        redirect_valid = 1'b0;
        got.delete();
        repeat (6) cyc();
        chk_seq("redir_dok", 32'h1C000200, 4);

        // misaligned redirect: single ADEF entry, then idle
        got.delete();
        redirect_valid = 1'b1; redirect_pc = 32'h1C000102;
        cyc();
        redirect_valid = 1'b0; saw_req = 1'b0;
        repeat (10) cyc();
        #1;
        chk("adef_noreq", 32'(saw_req), 32'd0);
        chk("adef_count", got.size(), 32'd1);
        if (got.size() > 0) begin
            chk("adef_pc", got[0].pc, 32'h1C000102);
            chk("adef_inst", got[0].inst, 32'h0);
            chk("adef_flag", 32'(got[0].adef), 32'd1);
        end
        chk("adef_idle_valid", 32'(fs_to_ds_valid), 32'd0);
        got.delete();
        redirect_valid = 1'b1; redirect_pc = 32'h1C000300;
        cyc();
        redirect_valid = 1'b0;
        repeat (6) cyc();
        chk_seq("adef_recover", 32'h1C000300, 4);

        // reset with the IBUF full
        ds_allow_in = 1'b0;
        repeat (8) cyc();
        #1;
        chk("full_valid", 32'(fs_to_ds_valid), 32'd1);
        chk("full_req", 32'(inst_sram_req), 32'd0);
        chk("full_head", fs_to_ds_pc, 32'h1C000310);
        reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(fs_to_ds_valid), 32'd0);
        chk("midrst_req", 32'(inst_sram_req), 32'd0);
        cyc();
        reset = 1'b0;
        bq.delete();
        #1;
        chk("postrst_valid", 32'(fs_to_ds_valid), 32'd0);
        chk("postrst_addr", inst_sram_addr, RST_PC);
        chk("postrst_req", 32'(inst_sram_req), 32'd1);
        got.delete();
        ds_allow_in = 1'b1;
        repeat (6) cyc();
        chk_seq("postrst", RST_PC, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
